adder_share_arbiter: RTL and testbench

- Time-shares one 32-bit combinational adder datapath (carry-lookahead class) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request channel per requester, single shared response channel tagged with requester ID.
- Sits between client blocks (accumulators, address generators) and the adder instance.
- Drives the adder's A/B/Cin inputs and captures Sum/Cout; it does not contain the adder itself.

---
 rtl/adder_share_pkg.sv | 12 +
 rtl/adder_share_rr_arbiter.sv | 33 +++
 rtl/adder_share_arbiter.sv | 101 ++++++++++
 tb/tb_adder_share_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types, default width and ID-width helper for the adder-share arbiter
package adder_share_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx
);

    logic found;

    // indices above ptr take priority, then wrap to indices at or below ptr
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++)
            if (!found && req[i] && ID_W'(i) > ptr) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        for (int i = 0; i < N; i++)
            if (!found && req[i] && ID_W'(i) <= ptr) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin time-sharing of one external adder; ADDER_SHARE_OVF_EN adds rsp_ovf
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
`ifdef ADDER_SHARE_OVF_EN
    output logic                     rsp_ovf,
`endif
    output logic                     busy
);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     gidx;
    logic [NUM_REQ-1:0]  grant;
    logic [WIDTH-1:0]    a_arr [NUM_REQ];
    logic [WIDTH-1:0]    b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // grants are offered only while idle and out of reset
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign busy      = state != IDLE;

    // FSM: accept in IDLE, capture adder result in CALC, hold response in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            owner     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|(req_valid & req_ready)) begin
                    add_a   <= a_arr[gidx];
                    add_b   <= b_arr[gidx];
                    add_cin <= req_cin[gidx];
                    owner   <= gidx;
                    ptr     <= gidx;
                    state   <= CALC;
                end
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= add_cout;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
`ifdef ADDER_SHARE_OVF_EN
                    rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
`endif
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: random + directed scoreboard bench with an adder model attached
module tb_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_cin = '0;
    logic [W-1:0]     add_a, add_b, add_sum;
    logic             add_cin, add_cout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic             busy;
`ifdef ADDER_SHARE_OVF_EN
    logic             rsp_ovf;
`endif

    always #5 clk = ~clk;

    // the shared adder the arbiter drives
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDER_SHARE_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        int         id;
        logic [W-1:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t         sbq[$];
    int           gseq[$];
    int           hcyc[$];
    int           pass_cnt = 0;
    int           tot_cnt = 0;
    int           cyc = 0;
    int           last = N - 1;
    bit           midle = 1'b1;
    bit           rsp_seen = 1'b0;
    bit           rst_seen = 1'b0;
    logic [N-1:0] gmask = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // next requester holding valid after 'from', in circular order
    function automatic int rr_pick(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) begin
            int j = (from + k) % N;
            if (((v >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    // expected response from plain integer arithmetic on the requester's operands
    function automatic exp_t model(input int i);
        exp_t e;
        logic [W-1:0] a, b;
        logic c;
        longint s;
        a = req_a[i*W +: W];
        b = req_b[i*W +: W];
        c = req_cin[i];
        {e.cout, e.sum} = 33'(a) + 33'(b) + 33'(c);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.id = i;
        e.cyc = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_seen = !rst_n;
    end

    // monitor: arbitration model pushes expectations, response side pops and compares
    always @(negedge clk) begin
        int g;
        exp_t e;
        logic [N-1:0] er;
        if (!rst_n) begin
            if (rst_seen) begin
                chk("reset_outputs", {rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b, add_cin, busy, req_ready}, '0);
`ifdef ADDER_SHARE_OVF_EN
                chk("reset_ovf", rsp_ovf, 0);
`endif
            end
            sbq.delete();
            last = N - 1;
            midle = 1'b1;
            rsp_seen = 1'b0;
            gmask = '0;
        end else begin
            gmask = req_valid & req_ready;
            if (midle) begin
                g = rr_pick(req_valid, last);
                er = (g < 0) ? '0 : N'(1) << g;
                chk("grant", req_ready, er);
                chk("busy_idle", busy, 0);
                if (g >= 0) begin
                    e = model(g);
                    e.cyc = cyc;
                    sbq.push_back(e);
                    last = g;
                    midle = 1'b0;
                    gseq.push_back(g);
                    hcyc.push_back(cyc);
                end
            end else begin
                chk("ready_when_busy", req_ready, 0);
                chk("busy", busy, 1);
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) chk("orphan_rsp", rsp_valid, 0);
                else begin
                    e = sbq[0];
                    if (!rsp_seen) chk("latency", cyc - e.cyc, 2);
                    rsp_seen = 1'b1;
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_cout", rsp_cout, e.cout);
`ifdef ADDER_SHARE_OVF_EN
                    chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        rsp_seen = 1'b0;
                        midle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i] = c;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 6)
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // one cycle of stimulus: mode 1 refreshes granted operands, mode 2 randomizes everything
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        if (mode == 2) rsp_ready = ($urandom % 4) != 0;
        for (int i = 0; i < N; i++) begin
            if (mode == 1 && gmask[i]) set_req(i, rnd_op(), rnd_op(), 1'($urandom % 2));
            if (mode == 2) begin
                if (req_valid[i] && !gmask[i]) begin
                    if ($urandom % 10 == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom % 2);
                    set_req(i, rnd_op(), rnd_op(), 1'($urandom % 2));
                end
            end
        end
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) step(mode);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (midle && sbq.size() == 0 && !rsp_valid) break;
        end
        if (k == 60) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_grant(input int i);
        int k;
        for (k = 0; k < 30; k++) begin
            @(negedge clk);
            if (|(req_ready & (N'(1) << i))) break;
        end
        if (k == 30) chk("grant_timeout", 0, 1);
    endtask

    task automatic do_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(posedge clk);
        #1;
        set_req(i, a, b, c);
        req_valid = N'(1) << i;
        wait_grant(i);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_one(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
        do_one(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_one(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

        // round robin from a fresh reset with every requester holding valid
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op(), 1'($urandom % 2));
        gseq.delete();
        hcyc.delete();
        rst_n = 1'b1;
        req_valid = '1;
        run(14, 1);
        req_valid = '0;
        wait_idle();
        chk("rr_count", gseq.size() >= 5, 1);
        if (gseq.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                chk("rr_order", gseq[i], i % N);
                if (i > 0) chk("rr_interval", hcyc[i] - hcyc[i-1], 3);
            end

        // backpressure with other requesters waiting
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        set_req(1, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        req_valid = 4'b0010;
        wait_grant(1);
        @(posedge clk);
        #1;
        req_valid = 4'b1101;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (k == 10) chk("bp_rsp_timeout", 0, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle();

        // reset while the operation is in CALC
        @(posedge clk);
        #1;
        set_req(2, 32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
        req_valid = 4'b0100;
        wait_grant(2);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        gseq.delete();
        rst_n = 1'b1;
        req_valid = '1;
        run(4, 1);
        req_valid = '0;
        wait_idle();
        chk("post_reset_first_grant", (gseq.size() > 0) ? gseq[0] : -1, 0);

        // skipping idle requesters with pointer parked at 1
        do_one(1, 32'h0000_00AA, 32'h0000_0055, 1'b0);
        @(posedge clk);
        #1;
        gseq.delete();
        req_valid = 4'b1010;
        run(7, 1);
        req_valid = '0;
        wait_idle();
        chk("skip_first", (gseq.size() > 0) ? gseq[0] : -1, 3);
        chk("skip_second", (gseq.size() > 1) ? gseq[1] : -1, 1);

        // randomized traffic with random response backpressure
        run(300, 2);
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
